id_writeback_stage: RTL and testbench
=====================================

# id_writeback_stage

Parametrised, registered successor of the stage-3 decode: it accepts one 24-bit instruction per handshake and drives a register-file write port. Write data comes from the immediate field, the accumulator, or a multi-cycle MMU load. A CID instruction runs a clear sequence over the upper registers. It sits between instruction decode and the register file, replacing the purely combinational write-select path with a stalling, handshaked stage.

## Interface
- DATA_WIDTH, 8, width of accumulator, MMU data and write data (8..16)
- REG_COUNT, 8, number of registers, which is also the write-mask width (1..8)
- CID_BASE, 4, lowest register index cleared by CID (0..REG_COUNT-1)

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  instruction offered
- in_ready  out  1  stage can accept
- instruction  in  24  opcode [23:20], field A [15:8], field B [7:0]
- accumulator  in  DATA_WIDTH  accumulator value
- mmu_data  in  DATA_WIDTH  load data
- mmu_valid  in  1  mmu_data valid this cycle
- mmu_req  out  1  load outstanding
- wr_en  out  1  register write strobe
- wr_mask  out  REG_COUNT  registers written
- wr_data  out  DATA_WIDTH  value written
- cid_busy  out  1  CID clear in progress
- cid_done  out  1  one-cycle pulse when the CID clear completes

## Operation
- States: IDLE, MEM_WAIT, CID_CLEAR.
- in_ready = 1 only in IDLE with rst_n high.
- Accept condition is in_valid & in_ready. On accept, the stage decodes the opcode:
  - 1xxx (accumulator move): mask = A[REG_COUNT-1:0]; data = accumulator as sampled at the accept edge. Stay in IDLE.
  - 0001 (immediate load): mask = A[REG_COUNT-1:0]; data = B zero-extended, or truncated when DATA_WIDTH < 8. Stay in IDLE.
  - 0010 (MMU load): latch mask = B[REG_COUNT-1:0]; go to MEM_WAIT.
  - 0110 (CID): go to CID_CLEAR.
  - Any other opcode: no write, stay in IDLE (NOP).
- MEM_WAIT:
  - mmu_req = 1.
  - On mmu_valid, register mmu_data as wr_data and drive the latched mask, then return to IDLE.
  - mmu_valid outside MEM_WAIT is ignored.
- wr_en = |wr_mask. A zero mask produces no strobe.
- wr_data is held at its last value whenever wr_en = 0.

## Timing
- Reset values:
  - Outputs: in_ready 0 while rst_n low, then 1; mmu_req 0; wr_en 0; wr_mask 0; wr_data 0; cid_busy 0; cid_done 0.
  - State: IDLE.
- Immediate and accumulator writes: wr_en is high exactly one cycle, in the cycle after accept (latency 1). Back-to-back accepts give back-to-back writes.
- MMU load:
  - mmu_req rises in the cycle after accept.
  - The write occurs in the cycle after the mmu_valid edge.
  - mmu_req falls in the same cycle as that write.
  - in_ready returns high in that same cycle.
  - mmu_valid asserted on the very first MEM_WAIT cycle is honoured (minimum load latency 2).
- CID: cid_busy is high from the cycle after accept through the final clear write. cid_done pulses together with the last wr_en.
- Reset mid-operation (rst_n low at any edge):
  - State returns to IDLE; the pending load is abandoned.
  - mmu_req, wr_en, cid_busy and cid_done are 0 in the cycle after that edge.
  - No write is issued for the abandoned instruction.
- in_valid held while in_ready = 0 is not consumed; the instruction must be re-presented.

## Configuration
- CID_SEQUENTIAL_EN defined: CID_CLEAR walks index i = CID_BASE .. REG_COUNT-1, one per cycle.
  - Each cycle: wr_mask = one-hot(i), wr_data = 0.
  - The sequence lasts REG_COUNT-CID_BASE cycles.
  - in_ready stays 0 until the cycle after the last write.
- CID_SEQUENTIAL_EN undefined: CID_CLEAR lasts one cycle.
  - In that cycle: wr_mask = all bits ≥ CID_BASE set, wr_data = 0, cid_busy = 1, cid_done = 1.
  - The stage returns to IDLE in the next cycle.

## Test plan
- Reset, defaults (DATA_WIDTH 8, REG_COUNT 8): after one cycle, in_ready = 1 and all other outputs 0.
- Immediate load: accept 0x1_03_5A. The next cycle gives wr_en = 1, wr_mask = 0x03, wr_data = 0x5A; the cycle after gives wr_en = 0.
- Accumulator move: accept 0x8_80_00 with accumulator 0xC3, then change accumulator to 0x11. The write shows mask 0x80, data 0xC3.
- MMU load: accept 0x2_00_0F.
  - mmu_req stays high for 3 cycles; in_ready stays 0.
  - mmu_valid is asserted with data 0xA7.
  - Next cycle: wr_mask = 0x0F, wr_data = 0xA7, mmu_req = 0.
- CID, both macro settings:
  - Defined: one-hot masks 0x10, 0x20, 0x40, 0x80 on consecutive cycles, with cid_done on the 0x80 write.
  - Undefined: a single write of mask 0xF0, data 0, with cid_done = 1.
- Reset during MEM_WAIT: pull rst_n low for one edge. mmu_req drops, no write occurs, and the later mmu_valid pulse produces no wr_en.

Source files
------------

// File: rtl/id_writeback_stage.sv
// Decode writeback: imm/acc/MMU-load/CID register-file writes; CID_SEQUENTIAL_EN walks CID clears one reg per cycle.
// Latency: imm/acc write 1 cycle after accept, MMU write 1 cycle after mmu_valid, CID write starts 1 cycle after accept.
// Backpressure: in_ready low outside IDLE (MEM_WAIT, CID_CLEAR) and during reset; held instructions are not consumed.
module id_writeback_stage #(
  parameter int DATA_WIDTH = 8,
  parameter int REG_COUNT  = 8,
  parameter int CID_BASE   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [23:0]           instruction,
  input  logic [DATA_WIDTH-1:0] accumulator,
  input  logic [DATA_WIDTH-1:0] mmu_data,
  input  logic                  mmu_valid,
  output logic                  mmu_req,
  output logic                  wr_en,
  output logic [REG_COUNT-1:0]  wr_mask,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  cid_busy,
  output logic                  cid_done
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MEM_WAIT  = 2'd1,
    CID_CLEAR = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [REG_COUNT-1:0]  mask_q, mask_d;
  logic [REG_COUNT-1:0]  ld_mask_q, ld_mask_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  logic                  accept;
  logic [3:0]            opcode;
  logic [REG_COUNT-1:0]  field_a_mask;
  logic [REG_COUNT-1:0]  field_b_mask;
  logic [DATA_WIDTH-1:0] imm_data;
  logic                  unused_bits;

`ifdef CID_SEQUENTIAL_EN
  localparam int IDX_W = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
  localparam logic [IDX_W-1:0] START_IDX = IDX_W'(CID_BASE);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(REG_COUNT - 1);
  logic [IDX_W-1:0] idx_q, idx_d;
`else
  localparam logic [REG_COUNT-1:0] CID_MASK = {REG_COUNT{1'b1}} << CID_BASE;
`endif

  assign opcode       = instruction[23:20];
  assign field_a_mask = instruction[8 +: REG_COUNT];
  assign field_b_mask = instruction[0 +: REG_COUNT];
  assign imm_data     = DATA_WIDTH'(instruction[7:0]);
  assign unused_bits  = ^instruction[19:16];

  assign in_ready = rst_n && (state_q == IDLE);
  assign accept   = in_valid && in_ready;
  assign mmu_req  = (state_q == MEM_WAIT);
  assign wr_en    = |mask_q;
  assign wr_mask  = mask_q;
  assign wr_data  = data_q;
  assign cid_busy = (state_q == CID_CLEAR);
`ifdef CID_SEQUENTIAL_EN
  assign cid_done = (state_q == CID_CLEAR) && (idx_q == LAST_IDX);
`else
  assign cid_done = (state_q == CID_CLEAR);
`endif

  always_comb begin
    state_d   = state_q;
    mask_d    = '0;
    data_d    = data_q;
    ld_mask_d = ld_mask_q;
`ifdef CID_SEQUENTIAL_EN
    idx_d     = idx_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (opcode[3]) begin
            mask_d = field_a_mask;
            data_d = accumulator;
          end else begin
            case (opcode[2:0])
              3'b001: begin
                mask_d = field_a_mask;
                data_d = imm_data;
              end
              3'b010: begin
                ld_mask_d = field_b_mask;
                state_d   = MEM_WAIT;
              end
              3'b110: begin
                state_d = CID_CLEAR;
                data_d  = '0;
`ifdef CID_SEQUENTIAL_EN
                idx_d   = START_IDX;
                mask_d  = REG_COUNT'(1) << START_IDX;
`else
                mask_d  = CID_MASK;
`endif
              end
              default: ;
            endcase
          end
        end
      end
      MEM_WAIT: begin
        if (mmu_valid) begin
          mask_d  = ld_mask_q;
          data_d  = mmu_data;
          state_d = IDLE;
        end
      end
      CID_CLEAR: begin
`ifdef CID_SEQUENTIAL_EN
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
        end else begin
          idx_d  = idx_q + IDX_W'(1);
          mask_d = REG_COUNT'(1) << idx_d;
          data_d = '0;
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
    // wr_data only moves when a strobe goes with it
    if (mask_d == '0) data_d = data_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mask_q    <= '0;
      data_q    <= '0;
      ld_mask_q <= '0;
`ifdef CID_SEQUENTIAL_EN
      idx_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      data_q    <= data_d;
      ld_mask_q <= ld_mask_d;
`ifdef CID_SEQUENTIAL_EN
      idx_q     <= idx_d;
`endif
    end
  end

endmodule

// File: tb/tb_id_writeback_stage.sv
// Randomized bench for id_writeback_stage with a queue-based reference model plus directed literal checks.
module tb_id_writeback_stage;
  localparam int DW = 8;
  localparam int RC = 8;
  localparam int CB = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [23:0]   instruction;
  logic [DW-1:0] accumulator;
  logic [DW-1:0] mmu_data;
  logic          mmu_valid;
  logic          mmu_req;
  logic          wr_en;
  logic [RC-1:0] wr_mask;
  logic [DW-1:0] wr_data;
  logic          cid_busy;
  logic          cid_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_writeback_stage #(.DATA_WIDTH(DW), .REG_COUNT(RC), .CID_BASE(CB)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .accumulator(accumulator), .mmu_data(mmu_data),
    .mmu_valid(mmu_valid), .mmu_req(mmu_req), .wr_en(wr_en), .wr_mask(wr_mask),
    .wr_data(wr_data), .cid_busy(cid_busy), .cid_done(cid_done)
  );

  // Reference model: what is visible this cycle, an outstanding load, and the queued CID clear writes.
  logic [RC-1:0] m_mask;
  logic [DW-1:0] m_data;
  logic          m_busy;
  logic          m_done;
  logic          m_pend;
  logic [RC-1:0] m_ld_mask;
  logic [RC-1:0] m_cid_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic model_ready();
    return !m_pend && !m_busy && (m_cid_q.size() == 0);
  endfunction

  task automatic model_update();
    logic [RC-1:0] n_mask;
    logic [DW-1:0] n_data;
    logic [RC-1:0] all_hi;
    logic [3:0]    op;
    logic          rdy;
    if (!rst_n) begin
      m_mask = '0; m_data = '0; m_busy = 1'b0; m_done = 1'b0; m_pend = 1'b0;
      m_cid_q.delete();
      return;
    end
    rdy    = model_ready();
    n_mask = '0;
    n_data = m_data;
    m_busy = 1'b0;
    m_done = 1'b0;
    op     = instruction[23:20];
    if (m_pend) begin
      if (mmu_valid) begin
        n_mask = m_ld_mask;
        n_data = mmu_data;
        m_pend = 1'b0;
      end
    end else if (rdy && in_valid) begin
      if (op >= 4'h8) begin
        n_mask = instruction[15:8];
        n_data = accumulator;
      end else if (op == 4'h1) begin
        n_mask = instruction[15:8];
        n_data = instruction[7:0];
      end else if (op == 4'h2) begin
        m_ld_mask = instruction[7:0];
        m_pend    = 1'b1;
      end else if (op == 4'h6) begin
`ifdef CID_SEQUENTIAL_EN
        for (int i = CB; i < RC; i++) m_cid_q.push_back(RC'(1) << i);
`else
        all_hi = '1;
        m_cid_q.push_back(all_hi << CB);
`endif
      end
    end
    if (m_cid_q.size() != 0) begin
      n_mask = m_cid_q.pop_front();
      n_data = '0;
      m_busy = 1'b1;
      m_done = (m_cid_q.size() == 0);
    end
    m_mask = n_mask;
    if (n_mask != '0) m_data = n_data;
  endtask

  task automatic check_model();
    chk("in_ready", 32'(in_ready), 32'(rst_n && model_ready()));
    chk("mmu_req",  32'(mmu_req),  32'(m_pend));
    chk("wr_en",    32'(wr_en),    32'(m_mask != '0));
    chk("wr_mask",  32'(wr_mask),  32'(m_mask));
    chk("wr_data",  32'(wr_data),  32'(m_data));
    chk("cid_busy", 32'(cid_busy), 32'(m_busy));
    chk("cid_done", 32'(cid_done), 32'(m_done));
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_model();
  endtask

  initial begin
    logic [3:0] op;
    logic [7:0] fa;
    logic [7:0] fb;
    rst_n = 1'b0; in_valid = 1'b0; instruction = '0; accumulator = '0;
    mmu_data = '0; mmu_valid = 1'b0;
    m_mask = '0; m_data = '0; m_busy = 1'b0; m_done = 1'b0; m_pend = 1'b0; m_ld_mask = '0;

    step();
    chk("rst_in_ready_low", 32'(in_ready), 32'd0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready_high", 32'(in_ready), 32'd1);
    chk("rst_outputs", {27'd0, mmu_req, wr_en, cid_busy, cid_done, |wr_data}, 32'd0);
    chk("rst_wr_mask", 32'(wr_mask), 32'd0);

    // immediate load 0x1_03_5A
    in_valid = 1'b1; instruction = 24'h10035A;
    step();
    in_valid = 1'b0;
    chk("imm_wr_en", 32'(wr_en), 32'd1);
    chk("imm_mask", 32'(wr_mask), 32'h03);
    chk("imm_data", 32'(wr_data), 32'h5A);
    step();
    chk("imm_wr_en_drop", 32'(wr_en), 32'd0);
    chk("imm_data_hold", 32'(wr_data), 32'h5A);

    // accumulator move; accumulator changes after accept
    in_valid = 1'b1; instruction = 24'h808000; accumulator = 8'hC3;
    step();
    in_valid = 1'b0; accumulator = 8'h11;
    chk("acc_mask", 32'(wr_mask), 32'h80);
    chk("acc_data", 32'(wr_data), 32'hC3);

    // MMU load with an unconsumed instruction offered during the wait
    in_valid = 1'b1; instruction = 24'h20000F;
    step();
    instruction = 24'h1FF33;
    for (int i = 0; i < 3; i++) begin
      chk("mmu_req_held", 32'(mmu_req), 32'd1);
      chk("mmu_not_ready", 32'(in_ready), 32'd0);
      if (i < 2) step();
    end
    in_valid = 1'b0; mmu_valid = 1'b1; mmu_data = 8'hA7;
    step();
    mmu_valid = 1'b0;
    chk("mmu_mask", 32'(wr_mask), 32'h0F);
    chk("mmu_data", 32'(wr_data), 32'hA7);
    chk("mmu_req_fall", 32'(mmu_req), 32'd0);
    chk("mmu_ready_back", 32'(in_ready), 32'd1);
    step();

    // CID
    in_valid = 1'b1; instruction = 24'h600000;
    step();
    in_valid = 1'b0;
`ifdef CID_SEQUENTIAL_EN
    for (int i = 0; i < 4; i++) begin
      chk("cid_seq_mask", 32'(wr_mask), 32'h10 << i);
      chk("cid_seq_busy", 32'(cid_busy), 32'd1);
      chk("cid_seq_done", 32'(cid_done), (i == 3) ? 32'd1 : 32'd0);
      step();
    end
`else
    chk("cid_mask", 32'(wr_mask), 32'hF0);
    chk("cid_data", 32'(wr_data), 32'h00);
    chk("cid_done", 32'(cid_done), 32'd1);
    step();
`endif
    chk("cid_ready_back", 32'(in_ready), 32'd1);
    chk("cid_idle", 32'(cid_busy), 32'd0);

    // reset during MEM_WAIT abandons the load
    in_valid = 1'b1; instruction = 24'h20000F;
    step();
    in_valid = 1'b0;
    chk("rstmem_req", 32'(mmu_req), 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rstmem_req_drop", 32'(mmu_req), 32'd0);
    chk("rstmem_no_wr", 32'(wr_en), 32'd0);
    mmu_valid = 1'b1; mmu_data = 8'h55;
    step();
    mmu_valid = 1'b0;
    chk("rstmem_late_valid", 32'(wr_en), 32'd0);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst_n    = ($urandom_range(0, 99) != 0);
      in_valid = ($urandom_range(0, 9) < 7);
      case ($urandom_range(0, 7))
        0, 1:    op = 4'h1;
        2:       op = 4'(8 + $urandom_range(0, 7));
        3, 4:    op = 4'h2;
        5:       op = 4'h6;
        default: op = 4'($urandom_range(0, 15));
      endcase
      fa = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      fb = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      instruction = {op, 4'($urandom_range(0, 15)), fa, fb};
      accumulator = DW'($urandom);
      mmu_data    = DW'($urandom);
      mmu_valid   = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
